fle_ccff_loader: RTL

- Sequences configuration of a chain of fle configuration flip-flops (ccff_head to ccff_tail) from a word-wide host stream.
- Serializes words into ccff_head and issues a per-cycle shift enable for the chain.
- Captures ccff_tail bits into readback words, so the previous chain contents can be read out while new contents load.
- Sits between the bitstream source and the clb/fle ccff chain, in the prog_clk domain.

---
 rtl/fle_ccff_loader_if.sv | 12 +
 rtl/fle_ccff_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fle_ccff_loader_if.sv
// Word-wide configuration stream between the bitstream source (master) and
// the ccff loader (slave).
interface fle_ccff_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/fle_ccff_loader.sv
// Serializes host configuration words into an fle ccff chain (bit 0 first) and
// reassembles the bits leaving ccff_tail into readback words, all in prog_clk.
module fle_ccff_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  fle_ccff_loader_if.slave  cfg,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int                WL_W       = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  WORD_W_CNT  = CNT_W'(WORD_W);
  localparam logic [WL_W-1:0]   WORD_W_WL   = WL_W'(WORD_W);
  localparam logic [WL_W-1:0]   WORD_LAST   = WL_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, FIN} state_e;

  state_e            state_q,     state_d;
  logic [WORD_W-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0]  bits_left_q, bits_left_d;
  logic [WL_W-1:0]   word_left_q, word_left_d;
  logic [WORD_W-1:0] rb_shreg_q,  rb_shreg_d;
  logic [WL_W-1:0]   rb_cnt_q,    rb_cnt_d;
  logic [WORD_W-1:0] rb_data_q,   rb_data_d;
  logic              rb_valid_q,  rb_valid_d;
  logic [WORD_W-1:0] rb_word;

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= '0;
      word_left_q <= '0;
      rb_shreg_q  <= '0;
      rb_cnt_q    <= '0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      word_left_q <= word_left_d;
      rb_shreg_q  <= rb_shreg_d;
      rb_cnt_q    <= rb_cnt_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    word_left_d = word_left_q;
    rb_shreg_d  = rb_shreg_q;
    rb_cnt_d    = rb_cnt_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    rb_word     = rb_shreg_q | (WORD_W'(ccff_tail) << rb_cnt_q);

    if (abort && (state_q != IDLE)) begin
      // Any partially assembled readback word is dropped; the chain keeps
      // whatever it has shifted so far.
      state_d    = IDLE;
      rb_shreg_d = '0;
      rb_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = FETCH;
            bits_left_d = CHAIN_LEN_C;
            rb_shreg_d  = '0;
            rb_cnt_d    = '0;
          end
        end
        FETCH: begin
          if (cfg.cfg_valid) begin
            shreg_d     = cfg.cfg_data;
            word_left_d = (bits_left_q >= WORD_W_CNT) ? WORD_W_WL : WL_W'(bits_left_q);
            state_d     = SHIFT;
          end
        end
        SHIFT: begin
          shreg_d     = shreg_q >> 1;
          bits_left_d = bits_left_q - CNT_W'(1);
          word_left_d = word_left_q - WL_W'(1);
          rb_shreg_d  = rb_word;
          rb_cnt_d    = rb_cnt_q + WL_W'(1);
          // Unfilled upper readback bits are still zero, which pads the last word.
          if ((rb_cnt_q == WORD_LAST) || (bits_left_q == CNT_W'(1))) begin
            rb_data_d  = rb_word;
            rb_valid_d = 1'b1;
            rb_shreg_d = '0;
            rb_cnt_d   = '0;
          end
          if (bits_left_q == CNT_W'(1)) begin
            state_d = FIN;
          end else if (word_left_q == WL_W'(1)) begin
            state_d = FETCH;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  always_comb begin
    busy          = (state_q != IDLE);
    ccff_en       = (state_q == SHIFT);
    ccff_head     = (state_q == SHIFT) && shreg_q[0];
    cfg.cfg_ready = (state_q == FETCH) && !abort;
    done          = (state_q == FIN) && !abort;
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule
